seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter that drives test and stimulus streams into the team's serial sequence detectors.
- Captures a PAT_W-bit pattern on a start request and shifts it out MSB first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Provides busy, done and per-frame markers for upstream control logic.

---
 rtl/seq_pattern_gen.sv | 195 +++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured PAT_W-bit pattern out MSB first, repeated N times with optional gaps.
// Latency: start sampled at edge k -> first bit on dout in the cycle after edge k; done pulses the cycle after the last bit.
// Backpressure: none; the stream runs at one bit per clock, and start is ignored unless IDLE. abort stops at the next edge.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, abort       transmission request (IDLE only) / immediate termination
//   pattern            bits to send, MSB first, captured on accepted start
//   repeat_cnt         number of repetitions, captured on accepted start
//   gap_len            idle cycles between repetitions, captured on accepted start
//   dout, dout_valid   serial bit and its qualifier (dout is 0 when not valid)
//   frame_start        first bit of each repetition
//   busy, done         SEND/GAP indicator, one-cycle completion pulse
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [PAT_W-1:0]   shreg;      // bits still to send, MSB is the current bit
    logic [PAT_W-1:0]   pat_q;      // captured pattern, reloaded for each repetition
    logic [IDX_W-1:0]   bit_idx;    // index of the bit currently on dout
    logic [CNT_W-1:0]   reps_left;  // repetitions still owed, including the current one
    logic [GAP_W-1:0]   gap_q;      // captured gap length
    logic [GAP_W-1:0]   gap_cnt;    // gap cycles remaining, including the current one

    logic accept;
    logic last_bit;
    logic more_reps;
    logic gap_end;

    assign accept    = start & ~abort;
    assign last_bit  = (bit_idx == '0);
    // More than one repetition owed means another frame follows the current one.
    assign more_reps = (reps_left > CNT_W'(1));
    assign gap_end   = (gap_cnt <= GAP_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (repeat_cnt == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (last_bit) begin
                    if (!more_reps) begin
                        next_state = S_DONE;
                    end else if (gap_q != '0) begin
                        next_state = S_GAP;
                    end else begin
                        next_state = S_SEND;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (gap_end) begin
                    next_state = S_SEND;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: shift register, bit index, repetition and gap counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            pat_q     <= '0;
            bit_idx   <= '0;
            reps_left <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg     <= pattern;
                        pat_q     <= pattern;
                        bit_idx   <= LAST_IDX;
                        reps_left <= repeat_cnt;
                        gap_q     <= gap_len;
                        gap_cnt   <= '0;
                    end
                end
                S_SEND: begin
                    if (!abort) begin
                        if (last_bit) begin
                            // Saturating decrement: the counter never wraps below 0.
                            if (reps_left != '0) begin
                                reps_left <= reps_left - CNT_W'(1);
                            end
                            if (more_reps && (gap_q == '0)) begin
                                // Back-to-back frame: reload with no bubble.
                                shreg   <= pat_q;
                                bit_idx <= LAST_IDX;
                            end else if (more_reps) begin
                                gap_cnt <= gap_q;
                            end
                        end else begin
                            shreg   <= shreg << 1;
                            bit_idx <= bit_idx - IDX_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (!abort) begin
                        if (gap_end) begin
                            shreg   <= pat_q;
                            bit_idx <= LAST_IDX;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs: decoded from registered state only, so no input reaches an output
    // combinationally, and reset clears every output immediately.
    always_comb begin
        dout        = 1'b0;
        dout_valid  = 1'b0;
        frame_start = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            S_SEND: begin
                dout        = shreg[PAT_W-1];
                dout_valid  = 1'b1;
                frame_start = (bit_idx == LAST_IDX);
                busy        = 1'b1;
            end
            S_GAP: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: each transaction's expected per-cycle output is
// built from the transmission rules (frames, gaps, done) and queued; a monitor compares
// every cycle's outputs against the queue head, expecting all-zero when the queue is empty.
module tb_seq_pattern_gen;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .gap_len     (gap_len),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    int total = 0;
    int bad   = 0;

    // Output vector layout: {done, busy, frame_start, dout_valid, dout}
    logic [4:0] exp_q[$];
    bit         mon_en = 1'b0;

    function automatic logic [4:0] obs();
        return {done, busy, frame_start, dout_valid, dout};
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b (done,busy,fs,vld,dout)", name, $time, got, want);
        end
    endtask

    // Monitor: one comparison per cycle, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        logic [4:0] want;
        if (mon_en) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 5'b00000;
            check("cycle", obs(), want);
        end
    end

    // Reference model + driver for one transaction. abort_at = cycle number (1-based after
    // the start edge) during which abort is held high; 0 means no abort.
    task automatic run_txn(input logic [PAT_W-1:0] pat, input int n, input int g,
                           input int abort_at, input bit noise);
        logic [4:0] seq[$];
        int active;
        seq = {};
        for (int r = 0; r < n; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                seq.push_back({1'b0, 1'b1, (b == PAT_W - 1), 1'b1, pat[b]});
            if (r < n - 1)
                for (int k = 0; k < g; k++) seq.push_back(5'b01000);
        end
        active = seq.size();
        if (abort_at > 0 && abort_at <= active) begin
            while (seq.size() > abort_at) seq.delete(seq.size() - 1);
        end else begin
            seq.push_back(5'b10000);
        end

        @(negedge clk);
        start      = 1'b1;
        abort      = 1'b0;
        pattern    = pat;
        repeat_cnt = CNT_W'(n);
        gap_len    = GAP_W'(g);
        @(posedge clk);
        #1;
        foreach (seq[i]) exp_q.push_back(seq[i]);
        for (int c = 1; c <= seq.size(); c++) begin
            @(negedge clk);
            if (noise) begin
                start      = 1'($urandom);
                pattern    = PAT_W'($urandom);
                repeat_cnt = CNT_W'($urandom);
                gap_len    = GAP_W'($urandom);
            end else begin
                start = 1'b0;
            end
            abort = (c == abort_at);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        gap_len    = '0;
        #1;
        check("reset_state", obs(), 5'b00000);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed scenarios
        run_txn(4'b1011, 1, 0, 0, 1'b0);   // single frame
        run_txn(4'b1011, 3, 0, 0, 1'b0);   // contiguous repetitions
        run_txn(4'b1011, 2, 2, 0, 1'b0);   // gap between frames
        run_txn(4'b1011, 0, 0, 0, 1'b0);   // zero repetitions -> done only
        run_txn(4'b1011, 1, 0, 2, 1'b0);   // abort mid-frame
        run_txn(4'b1011, 1, 0, 0, 1'b1);   // start/pattern noise while busy
        run_txn(4'b1101, 2, 3, 6, 1'b1);   // abort inside the gap
        run_txn(4'b1001, 15, 0, 0, 1'b0);  // maximum repeat count

        // Asynchronous reset in the middle of SEND
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        pattern    = 4'b1011;
        repeat_cnt = 4'd3;
        gap_len    = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_send", obs(), 5'b01010);
        rst_n = 1'b0;
        #1;
        check("async_reset", obs(), 5'b00000);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_txn(4'b0110, 1, 0, 0, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            logic [PAT_W-1:0] p;
            int n;
            int g;
            int a;
            int span;
            p    = PAT_W'($urandom);
            n    = $urandom_range(0, 6);
            if (t % 10 == 0) n = 15;
            g    = $urandom_range(0, 7);
            span = (n == 0) ? 0 : n * PAT_W + (n - 1) * g;
            a    = 0;
            if (span > 0 && $urandom_range(0, 3) == 0) a = $urandom_range(1, span);
            run_txn(p, n, g, a, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
